// File: rtl/stopwatch_bcd_core.sv
// Start/stop/clear MM:SS BCD stopwatch that counts the edges of the divider toggle output.
// The optional LAP_HOLD_EN build freezes the displayed digits while the lap hold flag is set.
module stopwatch_bcd_core #(
    parameter int TICK_BOTH_EDGES = 0,
    parameter int MIN_LIMIT       = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);
    localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);

    state_t     state_r, state_nxt_s;
    logic       tick_1_r, tick_2_r, ss_1_r, ss_2_r;
    logic       tick_ev_s, ss_ev_s, count_en_s, wrap_s;
    logic [3:0] so_r, st_r, mo_r, mt_r;
    logic [3:0] so_nxt_s, st_nxt_s, mo_nxt_s, mt_nxt_s;
    logic       running_r, rollover_r;

    // Two-flop edge detectors on the tick and start/stop levels
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_1_r <= 1'b0;
            tick_2_r <= 1'b0;
            ss_1_r   <= 1'b0;
            ss_2_r   <= 1'b0;
        end else begin
            tick_1_r <= tick_in;
            tick_2_r <= tick_1_r;
            ss_1_r   <= start_stop;
            ss_2_r   <= ss_1_r;
        end
    end

    // Event decode, next state and next live count
    always_comb begin
        if (TICK_BOTH_EDGES != 0) begin
            tick_ev_s = tick_1_r ^ tick_2_r;
        end else begin
            tick_ev_s = tick_1_r & ~tick_2_r;
        end
        ss_ev_s    = ss_1_r & ~ss_2_r;
        // The tick is judged against the current state, so a stop press still counts it
        count_en_s = (state_r == RUN) && tick_ev_s;
        wrap_s     = count_en_s && (so_r == 4'd9) && (st_r == 4'd5) &&
                     (mo_r == LIM_ONES) && (mt_r == LIM_TENS);
        so_nxt_s   = so_r;
        st_nxt_s   = st_r;
        mo_nxt_s   = mo_r;
        mt_nxt_s   = mt_r;
        if (count_en_s) begin
            if (so_r != 4'd9) begin
                so_nxt_s = so_r + 4'd1;
            end else begin
                so_nxt_s = 4'd0;
                if (st_r != 4'd5) begin
                    st_nxt_s = st_r + 4'd1;
                end else begin
                    st_nxt_s = 4'd0;
                    if ((mo_r == LIM_ONES) && (mt_r == LIM_TENS)) begin
                        mo_nxt_s = 4'd0;
                        mt_nxt_s = 4'd0;
                    end else if (mo_r != 4'd9) begin
                        mo_nxt_s = mo_r + 4'd1;
                    end else begin
                        mo_nxt_s = 4'd0;
                        mt_nxt_s = mt_r + 4'd1;
                    end
                end
            end
        end else begin
            so_nxt_s = so_r;
        end
        case (state_r)
            IDLE:    state_nxt_s = ss_ev_s ? RUN   : IDLE;
            RUN:     state_nxt_s = ss_ev_s ? PAUSE : RUN;
            PAUSE:   state_nxt_s = ss_ev_s ? RUN   : PAUSE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM, live count and status outputs; clear outranks every event
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_r    <= IDLE;
            so_r       <= 4'd0;
            st_r       <= 4'd0;
            mo_r       <= 4'd0;
            mt_r       <= 4'd0;
            running_r  <= 1'b0;
            rollover_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            so_r       <= so_nxt_s;
            st_r       <= st_nxt_s;
            mo_r       <= mo_nxt_s;
            mt_r       <= mt_nxt_s;
            running_r  <= (state_nxt_s == RUN);
            rollover_r <= wrap_s;
        end
    end

    assign running  = running_r;
    assign rollover = rollover_r;

`ifdef LAP_HOLD_EN
    logic       lap_1_r, lap_2_r, lap_ev_s, hold_r, hold_nxt_s;
    logic [3:0] so_d_r, st_d_r, mo_d_r, mt_d_r;

    // Lap press toggles the hold only in RUN; any start/stop press releases it
    always_comb begin
        lap_ev_s = lap_1_r & ~lap_2_r;
        if (ss_ev_s) begin
            hold_nxt_s = 1'b0;
        end else if (lap_ev_s && (state_r == RUN)) begin
            hold_nxt_s = ~hold_r;
        end else begin
            hold_nxt_s = hold_r;
        end
    end

    // Lap edge detect, hold flag and displayed digits
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_1_r <= 1'b0;
            lap_2_r <= 1'b0;
        end else begin
            lap_1_r <= lap;
            lap_2_r <= lap_1_r;
        end
        if (reset || clear) begin
            hold_r <= 1'b0;
            so_d_r <= 4'd0;
            st_d_r <= 4'd0;
            mo_d_r <= 4'd0;
            mt_d_r <= 4'd0;
        end else if (hold_nxt_s) begin
            hold_r <= 1'b1;
        end else begin
            hold_r <= 1'b0;
            so_d_r <= so_nxt_s;
            st_d_r <= st_nxt_s;
            mo_d_r <= mo_nxt_s;
            mt_d_r <= mt_nxt_s;
        end
    end

    assign sec_ones = so_d_r;
    assign sec_tens = st_d_r;
    assign min_ones = mo_d_r;
    assign min_tens = mt_d_r;
`else
    logic unused_lap_s;
    assign unused_lap_s = lap;
    assign sec_ones     = so_r;
    assign sec_tens     = st_r;
    assign min_ones     = mo_r;
    assign min_tens     = mt_r;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core built with MIN_LIMIT=1 so that rollover is reachable.
module tb_stopwatch_bcd_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover;
    int         n_cmp = 0;
    int         n_err = 0;

    stopwatch_bcd_core #(.TICK_BOTH_EDGES(0), .MIN_LIMIT(1)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens), .running(running), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_in = 1'b1;
            step();
            tick_in = 1'b0;
            step();
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
        step();
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    initial begin
        // Reset with tick toggling, then tick held high through release
        step();
        tick(3);
        tick_in = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        tick_in = 1'b0;
        step();
        check("reset_digits", digits(), 16'h0000);
        check("reset_running", {15'd0, running}, 16'd0);
        check("reset_rollover", {15'd0, rollover}, 16'd0);
        tick(4);
        check("idle_no_count", digits(), 16'h0000);

        // Start and verify the two-edge tick latency
        press_ss();
        check("start_running", {15'd0, running}, 16'd1);
        tick_in = 1'b1;
        step();
        check("latency_edge1", digits(), 16'h0000);
        tick_in = 1'b0;
        step();
        check("latency_edge2", digits(), 16'h0001);
        tick(11);
        check("count_12", digits(), 16'h0012);
        check("run_running", {15'd0, running}, 16'd1);

        // Climb to MIN_LIMIT:59 and wrap
        tick(107);
        check("at_limit", digits(), 16'h0159);
        tick_in = 1'b1;
        step();
        check("pre_wrap_rollover", {15'd0, rollover}, 16'd0);
        tick_in = 1'b0;
        step();
        check("wrap_digits", digits(), 16'h0000);
        check("wrap_rollover", {15'd0, rollover}, 16'd1);
        check("wrap_running", {15'd0, running}, 16'd1);
        step();
        check("rollover_one_cycle", {15'd0, rollover}, 16'd0);

        // Stop press coincident with a tick counts the tick
        tick(5);
        check("count_05", digits(), 16'h0005);
        tick_in = 1'b1;
        start_stop = 1'b1;
        step();
        tick_in = 1'b0;
        start_stop = 1'b0;
        step();
        check("stop_coincident", digits(), 16'h0006);
        check("paused_running", {15'd0, running}, 16'd0);
        tick(3);
        check("pause_hold", digits(), 16'h0006);
        tick_in = 1'b1;
        start_stop = 1'b1;
        step();
        tick_in = 1'b0;
        start_stop = 1'b0;
        step();
        check("start_coincident", digits(), 16'h0006);
        check("resume_running", {15'd0, running}, 16'd1);
        tick(1);
        check("resume_count", digits(), 16'h0007);

        // Clear wins over a coincident tick and start/stop press
        tick(30);
        check("count_37", digits(), 16'h0037);
        clear = 1'b1;
        tick_in = 1'b1;
        start_stop = 1'b1;
        step();
        step();
        check("clear_digits", digits(), 16'h0000);
        check("clear_running", {15'd0, running}, 16'd0);
        check("clear_rollover", {15'd0, rollover}, 16'd0);
        clear = 1'b0;
        tick_in = 1'b0;
        start_stop = 1'b0;
        step();
        tick(3);
        check("clear_idle", digits(), 16'h0000);
        check("clear_idle_running", {15'd0, running}, 16'd0);

        // Reset mid-count
        press_ss();
        tick(3);
        check("count_03", digits(), 16'h0003);
        reset = 1'b1;
        step();
        check("reset_mid_digits", digits(), 16'h0000);
        check("reset_mid_running", {15'd0, running}, 16'd0);
        reset = 1'b0;
        step();

        // Lap press: held snapshot when enabled, ignored otherwise
        press_ss();
        tick(10);
        check("count_10", digits(), 16'h0010);
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        tick(5);
`ifdef LAP_HOLD_EN
        check("lap_hold", digits(), 16'h0010);
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        check("lap_release", digits(), 16'h0015);
`else
        check("lap_ignored", digits(), 16'h0015);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
- Consumer of the free-running divider toggle output. Turns it into a start/stop/clear stopwatch counting MM:SS in BCD for the display driver.
- Sits directly downstream of the clock divider and upstream of the seven-segment mux.
- Everything runs in the single system clock domain. The divider output is treated as a level to be edge-detected, never used as a clock.

Parameters:
- TICK_BOTH_EDGES, 0, 0 = count on rising edges of tick_in only; 1 = count on both edges.
- MIN_LIMIT, 59, last minute value before wrap, decimal 1..99, applied to the BCD minute pair.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick_in  input  1  toggle output of the divider, a level signal.
- start_stop  input  1  debounced button level; each rising edge is one press.
- clear  input  1  level; while high, forces the count to zero.
- lap  input  1  debounced button level; rising edge = press. Used only with LAP_HOLD_EN.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens.
- running  output  1  high in the RUN state.
- rollover  output  1  one-cycle pulse when the count wraps from MIN_LIMIT:59 to 00:00.

Behaviour:
- Reset is synchronous and active-high on clk. All of the following go to 0 at reset:
  - state (IDLE)
  - all digit registers
  - running and rollover
  - edge-detect flops for tick_in and start_stop
  - the lap flops
- Edge detection uses a two-flop pipeline, t1<=tick_in and t2<=t1.
  - tick_ev = t1&~t2, or t1^t2 when TICK_BOTH_EDGES=1.
  - start_stop uses the same scheme and produces ss_ev.
- Latency: tick_in rises before edge k, t1 captures it at edge k, and the digits update at edge k+1.
- All outputs are registered. There is no combinational input-to-output path.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: ss_ev -> RUN.
  - RUN: ss_ev -> PAUSE.
  - PAUSE: ss_ev -> RUN.
  - Any state: clear=1 -> IDLE with all digits 0. clear has priority over ss_ev and tick_ev.
- A tick_ev is counted only if the state at that edge is RUN.
  - If ss_ev and tick_ev occur in the same cycle, the tick is applied according to the current state, then the state transitions.
  - So a stop press coincident with a tick still counts that tick, and a start press coincident with a tick does not count it.
- Increment rules:
  - sec_ones 0..9; at 9 it wraps to 0 and carries into sec_tens.
  - sec_tens 0..5; at 5 with a carry in, it wraps to 0 and carries into the minutes.
  - The minutes pair counts 00..MIN_LIMIT in BCD (min_ones 0..9, min_tens carries).
  - When the count is MIN_LIMIT:59 and a tick arrives, all digits become 0, rollover=1 for exactly that cycle, and the state stays RUN.
- rollover is 0 in every other cycle, including during clear.
- Digits hold their values in PAUSE and IDLE.
- Reset or clear asserted mid-count takes effect at the next edge. There is no partial update.
- tick_in held high through reset release gives t1=1, t2=0 for one cycle: one spurious tick_ev, which is ignored because the state is IDLE.

Optional Feature:
- Macro: LAP_HOLD_EN.
- Defined:
  - A rising edge on lap (two-flop detect) while in RUN toggles a hold flag.
  - While the hold flag is set, the digit outputs show a snapshot latched at the press. The internal count keeps advancing.
  - A second lap press, or any ss_ev, clears the flag and the outputs resume showing the live count on the next cycle.
  - clear and reset clear the flag.
  - rollover still reflects the internal count.
- Undefined: the lap port exists but is ignored, and the outputs always show the live count.

Test Plan:
- Reset with tick_in toggling -> all digits 0, running=0, rollover=0, and no count advance while in IDLE.
- start_stop press, then 12 rising edges of tick_in -> running=1 and outputs 00:12. Each digit update occurs exactly 2 clk edges after the tick_in rise is applied.
- Preload to MIN_LIMIT:59 by ticking (MIN_LIMIT=1, 119 ticks) -> 01:59; the next tick gives 00:00 with rollover high for 1 cycle and running still 1.
- ss_ev coincident with tick_ev in RUN at 00:05 -> 00:06 and state PAUSE. Further ticks leave 00:06. Pressing again with a coincident tick -> stays 00:06, state RUN.
- clear asserted in RUN at 00:37 together with a tick and a start_stop press -> 00:00, IDLE, running=0, rollover=0.
- LAP_HOLD_EN: lap at 00:10 followed by 5 ticks -> outputs 00:10. A second lap press -> outputs 00:15 the next cycle.
